// File: rtl/btn_pkg.sv
// btn_pkg: shared constants, FSM state type and round-robin picker for the button event arbiter
package btn_pkg;
  localparam int NUM_BTN = 3;
  localparam int BTN_ID_W = 2;
  typedef enum logic {IDLE, PRESENT} state_t;
  function automatic logic [BTN_ID_W-1:0] rr_pick(input logic [NUM_BTN-1:0] req, input logic [BTN_ID_W-1:0] last);
    logic [BTN_ID_W-1:0] id;
    id = '0;
    for (int k = NUM_BTN; k >= 1; k--)
      if (req[(int'(last) + k) % NUM_BTN]) id = BTN_ID_W'((int'(last) + k) % NUM_BTN);
    return id;
  endfunction
endpackage

// File: rtl/btn_repeat_timer.sv
// btn_repeat_timer: pulses once after HOLD_CYCLES of level high, then every REPEAT_CYCLES
//   clk, reset (async active-low), level (button level in), fire (synthetic rise out)
module btn_repeat_timer #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic fire
);
  localparam int MAX_C = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int W = $clog2(MAX_C + 1);
  logic [W-1:0] cnt;
  logic rep;
  // cnt equals the number of earlier cycles spent high since the last pulse (or since the press)
  assign fire = level & (cnt == (rep ? W'(REPEAT_CYCLES) : W'(HOLD_CYCLES)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      rep <= 1'b0;
    end else begin
      cnt <= !level ? '0 : fire ? W'(1) : cnt + W'(1);
      rep <= level & (rep | fire);
    end
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: edge-detects three buttons and presents their events one at a time, round-robin
//   clk, reset (async active-low), db[2:0] debounced levels, evt_ready consumer accept
//   evt_valid/evt_id presented event, pending[2:0] queued events, overrun[2:0] sticky lost-event flags
//   BTN_AUTOREPEAT_EN: adds per-button auto-repeat via btn_repeat_timer
module btn_event_arbiter import btn_pkg::*; #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  db,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [BTN_ID_W-1:0] evt_id,
  output logic [NUM_BTN-1:0]  pending,
  output logic [NUM_BTN-1:0]  overrun
);
  state_t state;
  logic [NUM_BTN-1:0] db_q, rise, grant;
  logic [BTN_ID_W-1:0] last_grant, pick;
`ifdef BTN_AUTOREPEAT_EN
  logic [NUM_BTN-1:0] syn;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_tmr
    btn_repeat_timer #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_tmr (
      .clk(clk), .reset(reset), .level(db[i]), .fire(syn[i])
    );
  end
  assign rise = (db & ~db_q) | syn;
`else
  assign rise = db & ~db_q;
`endif
  assign pick = rr_pick(pending, last_grant);
  assign grant = (state == IDLE && |pending) ? NUM_BTN'(1) << pick : '0;
  // a rise on the bit being granted re-arms it as a fresh event instead of counting as lost
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      db_q <= '0;
      pending <= '0;
      overrun <= '0;
      evt_valid <= 1'b0;
      evt_id <= '0;
      last_grant <= BTN_ID_W'(NUM_BTN - 1);
    end else begin
      db_q <= db;
      pending <= (pending & ~grant) | rise;
      overrun <= overrun | (rise & pending & ~grant);
      if (state == IDLE) begin
        if (|pending) begin
          state <= PRESENT;
          evt_valid <= 1'b1;
          evt_id <= pick;
        end
      end else if (evt_ready) begin
        state <= IDLE;
        evt_valid <= 1'b0;
        last_grant <= evt_id;
      end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed and randomized checks of btn_event_arbiter against an event-level model
module tb_btn_event_arbiter;
  localparam int HOLD = 8;
  localparam int REP = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] db = '0;
  logic evt_ready = 1'b0;
  logic evt_valid;
  logic [1:0] evt_id;
  logic [2:0] pending, overrun;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs[$];
  int hs_t[$];
  bit m_busy;
  int m_id, m_last;
  bit [2:0] m_pend, m_ovr, m_prev;
  int m_len[3];

  btn_event_arbiter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset), .db(db), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_last = 2; m_pend = '0; m_ovr = '0; m_prev = '0;
    for (int i = 0; i < 3; i++) m_len[i] = 0;
  endtask

  // Event-level reference: a press (or, with auto-repeat, hold lengths 8, 12, 16, ...) is an event;
  // the arbiter presents one event at a time, picking the next waiting button after the last served.
  task automatic model_step(input bit [2:0] d, input bit r);
    bit [2:0] rs, g;
    int p;
    for (int i = 0; i < 3; i++)
      rs[i] = d[i] && (!m_prev[i] || (AR && m_len[i] >= HOLD && (m_len[i] - HOLD) % REP == 0));
    g = '0;
    p = -1;
    if (!m_busy && m_pend != 0) begin
      for (int k = 1; k <= 3; k++)
        if (p < 0 && m_pend[(m_last + k) % 3]) p = (m_last + k) % 3;
      g[p] = 1'b1;
    end
    m_ovr |= rs & m_pend & ~g;
    m_pend = (m_pend & ~g) | rs;
    if (p >= 0) begin
      m_busy = 1; m_id = p;
    end else if (m_busy && r) begin
      m_busy = 0; m_last = m_id;
    end
    for (int i = 0; i < 3; i++) m_len[i] = d[i] ? m_len[i] + 1 : 0;
    m_prev = d;
  endtask

  task automatic step(input logic [2:0] d, input logic r);
    db = d;
    evt_ready = r;
    if (evt_valid === 1'b1 && r) begin
      hs.push_back(int'(evt_id));
      hs_t.push_back(cyc);
    end
    model_step(d, r);
    @(posedge clk);
    #1;
    cyc++;
    chk("evt_valid", 32'(evt_valid), 32'(m_busy));
    chk("evt_id", 32'(evt_id), 32'(m_id));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    db = '0;
    evt_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overrun", 32'(overrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    hs.delete();
    hs_t.delete();
  endtask

  initial begin
    logic [2:0] d;
    #2;
    do_reset();
    // single press of button 1
    step(3'b000, 1);
    step(3'b010, 1);
    chk("single_lat1", 32'(evt_valid), 0);
    chk("single_pend", 32'(pending), 32'b010);
    step(3'b010, 1);
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_id", 32'(evt_id), 1);
    step(3'b010, 1);
    chk("single_drop", 32'(evt_valid), 0);
    chk("single_pend0", 32'(pending), 0);
    step(3'b000, 1);
    chk("single_cnt", hs.size(), 1);
    // simultaneous press
    do_reset();
    for (int i = 0; i < 7; i++) step(3'b111, 1);
    for (int i = 0; i < 2; i++) step(3'b000, 1);
    chk("sim_cnt", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("sim_id0", hs[0], 0);
      chk("sim_id1", hs[1], 1);
      chk("sim_id2", hs[2], 2);
      chk("sim_gap", hs_t[1] - hs_t[0], 2);
      chk("sim_gap2", hs_t[2] - hs_t[1], 2);
    end
    // stall on button 2
    do_reset();
    step(3'b100, 0);
    step(3'b000, 0);
    for (int i = 0; i < 20; i++) begin
      step(3'b000, 0);
      chk("stall_valid", 32'(evt_valid), 1);
      chk("stall_id", 32'(evt_id), 2);
    end
    step(3'b000, 1);
    chk("stall_done", 32'(evt_valid), 0);
    chk("stall_hs", hs.size(), 1);
    // overrun on button 0
    do_reset();
    step(3'b001, 0);
    step(3'b000, 0);
    step(3'b001, 0);
    step(3'b000, 0);
    step(3'b001, 0);
    chk("ovr_set", 32'(overrun), 32'b001);
    for (int i = 0; i < 5; i++) step(3'b000, 1);
    chk("ovr_sticky", 32'(overrun), 32'b001);
    // hold for auto-repeat
    do_reset();
    for (int i = 0; i < 20; i++) step(3'b001, 1);
    for (int i = 0; i < 4; i++) step(3'b000, 1);
    chk("repeat_cnt", hs.size(), AR ? 4 : 1);
    if (AR && hs.size() == 4) begin
      chk("repeat_gap1", hs_t[1] - hs_t[0], HOLD);
      chk("repeat_gap2", hs_t[2] - hs_t[1], REP);
    end
    // randomized traffic
    do_reset();
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d = 3'($urandom_range(0, 7));
      step(d, 1'($urandom_range(0, 1)));
    end
    // reset in the middle of a presented event
    do_reset();
    step(3'b100, 0);
    step(3'b000, 0);
    step(3'b100, 0);
    step(3'b000, 0);
    step(3'b100, 0);
    chk("mid_valid_pre", 32'(evt_valid), 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(3'b111, 1);
    chk("mid_first", hs.size() > 0 ? hs[0] : -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, meaning cycles a button must stay high before the first auto-repeat event.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10000000, meaning cycles between subsequent auto-repeat events.
REQ-003 The block SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port db  input  3  debounced button levels, already synchronous to clk.
REQ-006 The block SHALL have port evt_ready  input  1  consumer (game FSM) accepts the event.
REQ-007 The block SHALL have port evt_valid  output  1  an event is presented.
REQ-008 The block SHALL have port evt_id  output  2  index of the granted button, 0..2.
REQ-009 The block SHALL have port pending  output  3  per-button event waiting for grant.
REQ-010 The block SHALL have port overrun  output  3  sticky per-button event-lost flag.

Function
REQ-011 The block SHALL register db into db_q each cycle; rise[i] = db[i] & ~db_q[i].
REQ-012 A rise[i] SHALL set pending[i] at the next clock edge.
REQ-013 A rise[i] while pending[i] is already set and not being granted in that cycle SHALL set overrun[i]; overrun[i] SHALL stay set until reset.
REQ-014 The FSM SHALL have states IDLE and PRESENT; reset state is IDLE.
REQ-015 IDLE: if pending != 0, the FSM SHALL grant round-robin, searching from (last_grant+1) mod 3 upward, load evt_id, clear the granted pending bit and go to PRESENT; otherwise it stays in IDLE.
REQ-016 PRESENT: evt_valid SHALL be 1, and evt_id SHALL be held stable until a cycle with evt_ready=1.
REQ-017 On evt_valid & evt_ready, the FSM SHALL update last_grant to evt_id and return to IDLE; evt_valid is 0 in IDLE.
REQ-018 Latency: with the FSM in IDLE, evt_valid SHALL assert on the second clock edge after the cycle in which rise[i] is sampled.
REQ-019 Maximum throughput SHALL be one event per two cycles.
REQ-020 A rise[i] in the same cycle that pending[i] is granted SHALL leave pending[i] set (a new event) and SHALL NOT set overrun[i].
REQ-021 evt_id SHALL never be 3; evt_ready while in IDLE SHALL be ignored.

Reset
REQ-022 Reset assertion SHALL immediately clear evt_valid, pending, overrun, db_q, and all counters, SHALL set evt_id=0 and FSM=IDLE, and SHALL set last_grant=2 so button 0 has first priority.
REQ-023 Reset mid-handshake SHALL drop the presented event without completion.

Configuration
REQ-024 With macro BTN_AUTOREPEAT_EN defined, each button SHALL have a hold counter running while db[i]=1 and cleared while db[i]=0.
REQ-025 With BTN_AUTOREPEAT_EN defined, reaching HOLD_CYCLES SHALL generate a synthetic rise[i], followed by another every REPEAT_CYCLES while db[i] stays high; synthetic rises SHALL obey REQ-012, REQ-013 and REQ-020.
REQ-026 Without BTN_AUTOREPEAT_EN, no counters SHALL exist, and events SHALL come from real rising edges only.

Structure
REQ-027 A shared package btn_pkg SHALL hold NUM_BTN=3, the BTN_ID_W=2 constant, and the FSM state typedef (IDLE, PRESENT).
REQ-028 The per-button repeat counter SHALL be the sub-module btn_repeat_timer, instantiated 3 times, and only under BTN_AUTOREPEAT_EN.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4)
REQ-029 Single press: db=3'b010 from cycle 10, evt_ready=1 -> evt_valid=1 with evt_id=1 at cycle 12 for one cycle, and pending=0 after.
REQ-030 Simultaneous press: db 000->111, evt_ready=1 -> ids 0, 1, 2 in order, each valid one cycle, events 2 cycles apart.
REQ-031 Stall: press btn2, evt_ready=0 for 20 cycles -> evt_valid and evt_id=2 held stable for all 20 cycles; transfer completes on the first evt_ready=1 cycle.
REQ-032 Overrun: evt_ready=0, btn0 pressed, released, pressed again while pending[0]=1 -> overrun=3'b001, which persists until reset.
REQ-033 Auto-repeat (macro on): hold db[0]=1 for 20 cycles, evt_ready=1 -> events at the initial rise, then after 8 cycles, then every 4 cycles; with macro off, exactly one event.
REQ-034 Reset mid-operation: assert reset while evt_valid=1 -> evt_valid, pending and overrun read 0 immediately; after release, the first grant among simultaneous presses goes to id 0.
